// File: rtl/pll_cen_pkg.sv
// Shared types and helpers for the lock-qualified reset sequencer and clock-enable generator.
// Ratio fields are sized for the widest supported accumulator (ACC_W <= RATIO_MAX_W).
package pll_cen_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } pllState_t;

   localparam int RATIO_MAX_W = 32;

   typedef struct packed {
      logic [RATIO_MAX_W-1:0] num;
      logic [RATIO_MAX_W-1:0] den;
   } ratio_t;

   // Width of a counter that must reach lockHold-1; never narrower than one bit.
   function automatic int HOLD_W(input int lockHold);
      return (lockHold > 1) ? $clog2(lockHold) : 1;
   endfunction

   // A ratio is usable only with a nonzero denominator and a rate of at most one.
   function automatic logic ratioValid(input ratio_t r);
      return (r.den != '0) && (r.num <= r.den);
   endfunction

endpackage

// File: rtl/pll_cen_acc.sv
// One channel's fractional-rate accumulator: emits a registered single-cycle enable
// whenever the running sum of num crosses den.
module pll_cen_acc #(
   parameter int ACC_W = 16
) (
   input  logic             refclk,
   input  logic [ACC_W-1:0] num,
   input  logic [ACC_W-1:0] den,
   input  logic             run,
   input  logic             clear,
   output logic             cen
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             cen_q, cen_d;
   logic [ACC_W:0]   sum;

   // Sum carries one extra bit so acc + num never wraps before the compare.
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, num};
      acc_d = '0;
      cen_d = 1'b0;
      if (run && !clear) begin
         if (sum >= {1'b0, den}) begin
            acc_d = ACC_W'(sum - {1'b0, den});
            cen_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge refclk) begin
      acc_q <= acc_d;
      cen_q <= cen_d;
   end

   assign cen = cen_q;

endmodule

// File: rtl/pll_cen_gen.sv
// Lock-qualified reset sequencer plus CHANNELS fractional clock-enable generators.
// Optional runtime ratio programming is enabled by defining PLL_CEN_DYN_RATIO_EN.
module pll_cen_gen
   import pll_cen_pkg::*;
#(
   parameter int                        CHANNELS  = 4,
   parameter int                        ACC_W     = 16,
   parameter logic [CHANNELS*ACC_W-1:0] NUM       = {CHANNELS{ACC_W'(1)}},
   parameter logic [CHANNELS*ACC_W-1:0] DEN       = {CHANNELS{ACC_W'(2)}},
   parameter int                        LOCK_HOLD = 1024
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  pll_locked,
   input  logic [CHANNELS-1:0]   run_mask,
`ifdef PLL_CEN_DYN_RATIO_EN
   input  logic                  cfg_we,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
   input  logic [ACC_W-1:0]      cfg_num,
   input  logic [ACC_W-1:0]      cfg_den,
`endif
   output logic [CHANNELS-1:0]   cen,
   output logic                  rst_out,
   output logic                  ready,
   output logic                  unlock_err
);

   localparam int              HW        = HOLD_W(LOCK_HOLD);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(LOCK_HOLD - 1);

   pllState_t           state_q, state_d;
   logic [HW-1:0]       holdCnt_q, holdCnt_d;
   logic                rstOut_q, rstOut_d;
   logic                ready_q, ready_d;
   logic                unlockErr_q, unlockErr_d;
   logic [CHANNELS-1:0] chanRun;
   logic [CHANNELS-1:0] cfgClear;
   logic [ACC_W-1:0]    chNum [CHANNELS];
   logic [ACC_W-1:0]    chDen [CHANNELS];

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= WAIT_LOCK;
         holdCnt_q   <= '0;
         rstOut_q    <= 1'b1;
         ready_q     <= 1'b0;
         unlockErr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         holdCnt_q   <= holdCnt_d;
         rstOut_q    <= rstOut_d;
         ready_q     <= ready_d;
         unlockErr_q <= unlockErr_d;
      end
   end

   // Any drop of lock restarts qualification from scratch.
   always_comb begin
      state_d   = state_q;
      holdCnt_d = '0;
      case (state_q)
         WAIT_LOCK: if (pll_locked) state_d = HOLD;
         HOLD: begin
            if (!pll_locked) begin
               state_d = WAIT_LOCK;
            end else if (holdCnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               holdCnt_d = holdCnt_q + HW'(1);
            end
         end
         RUN:       if (!pll_locked) state_d = WAIT_LOCK;
         default:   state_d = WAIT_LOCK;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_comb begin
      rstOut_d    = (state_d != RUN);
      ready_d     = (state_d == RUN);
      unlockErr_d = unlockErr_q | ((state_q == RUN) && !pll_locked);
   end

   assign rst_out    = rstOut_q;
   assign ready      = ready_q;
   assign unlock_err = unlockErr_q;

   // Requiring RUN on both sides of the edge clears every channel on the edge that leaves RUN.
   assign chanRun = ((state_q == RUN) && (state_d == RUN)) ? run_mask : '0;

`ifdef PLL_CEN_DYN_RATIO_EN
   ratio_t ratio_q [CHANNELS];
   ratio_t wrRatio;
   logic   wrOk;

   always_comb begin
      wrRatio.num = RATIO_MAX_W'(cfg_num);
      wrRatio.den = RATIO_MAX_W'(cfg_den);
      wrOk        = cfg_we && ratioValid(wrRatio) && (int'(cfg_ch) < CHANNELS);
      for (int i = 0; i < CHANNELS; i++) begin
         cfgClear[i] = wrOk && (int'(cfg_ch) == i);
         chNum[i]    = ratio_q[i].num[ACC_W-1:0];
         chDen[i]    = ratio_q[i].den[ACC_W-1:0];
      end
   end

   always_ff @(posedge refclk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (rst) begin
            ratio_q[i].num <= RATIO_MAX_W'(NUM[i*ACC_W +: ACC_W]);
            ratio_q[i].den <= RATIO_MAX_W'(DEN[i*ACC_W +: ACC_W]);
         end else if (cfgClear[i]) begin
            ratio_q[i] <= wrRatio;
         end
      end
   end
`else
   always_comb begin
      cfgClear = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         chNum[i] = NUM[i*ACC_W +: ACC_W];
         chDen[i] = DEN[i*ACC_W +: ACC_W];
      end
   end
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : genChan
      pll_cen_acc #(
         .ACC_W (ACC_W)
      ) uAcc (
         .refclk (refclk),
         .num    (chNum[g]),
         .den    (chDen[g]),
         .run    (chanRun[g]),
         .clear  (rst | cfgClear[g]),
         .cen    (cen[g])
      );
   end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Self-checking bench for pll_cen_gen: directed lock/ratio/mask scenarios followed by
// randomized stimulus, all compared against a lock-streak and pulse-count reference model.
module tb_pll_cen_gen;

   localparam int          CHANNELS  = 4;
   localparam int          ACC_W     = 16;
   localparam int          LOCK_HOLD = 8;
   localparam logic [63:0] NUM_P     = {16'd0, 16'd1, 16'd2, 16'd1};
   localparam logic [63:0] DEN_P     = {16'd7, 16'd1, 16'd5, 16'd3};

   logic       refclk     = 1'b0;
   logic       rst        = 1'b1;
   logic       pll_locked = 1'b0;
   logic [3:0] run_mask   = 4'h0;
   logic [3:0] cen;
   logic       rst_out;
   logic       ready;
   logic       unlock_err;
`ifdef PLL_CEN_DYN_RATIO_EN
   logic        cfg_we  = 1'b0;
   logic [1:0]  cfg_ch  = 2'd0;
   logic [15:0] cfg_num = 16'd0;
   logic [15:0] cfg_den = 16'd0;
`endif

   int checks = 0;
   int errors = 0;

   int         streak   = 0;
   bit         expReady = 1'b0;
   bit         expErr   = 1'b0;
   logic [3:0] expCen   = 4'h0;
   longint     phase [4];
   longint     mNum  [4];
   longint     mDen  [4];

   pll_cen_gen #(
      .CHANNELS  (CHANNELS),
      .ACC_W     (ACC_W),
      .NUM       (NUM_P),
      .DEN       (DEN_P),
      .LOCK_HOLD (LOCK_HOLD)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .run_mask   (run_mask),
`ifdef PLL_CEN_DYN_RATIO_EN
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_num    (cfg_num),
      .cfg_den    (cfg_den),
`endif
      .cen        (cen),
      .rst_out    (rst_out),
      .ready      (ready),
      .unlock_err (unlock_err)
   );

   always #5 refclk = ~refclk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic l, input logic [3:0] m);
      rst        = r;
      pll_locked = l;
      run_mask   = m;
   endtask

   // Reference model: release after LOCK_HOLD+1 consecutive locked cycles; channel pulses
   // come from the integer part of (active cycles * NUM / DEN) stepping up.
   task automatic modelEdge();
      bit readyPrev;
      bit wrHit [4];
      readyPrev = expReady;
      for (int c = 0; c < 4; c++) wrHit[c] = 1'b0;
`ifdef PLL_CEN_DYN_RATIO_EN
      if (!rst && cfg_we && (cfg_den != 16'd0) && (cfg_num <= cfg_den)) wrHit[cfg_ch] = 1'b1;
`endif
      if (rst || !pll_locked) streak = 0;
      else streak++;
      expReady = !rst && (streak >= LOCK_HOLD + 1);
      expErr   = !rst && (expErr || (readyPrev && !pll_locked));
      for (int c = 0; c < 4; c++) begin
         if (rst) begin
            mNum[c] = longint'(NUM_P[c*16 +: 16]);
            mDen[c] = longint'(DEN_P[c*16 +: 16]);
         end
`ifdef PLL_CEN_DYN_RATIO_EN
         else if (wrHit[c]) begin
            mNum[c] = longint'(cfg_num);
            mDen[c] = longint'(cfg_den);
         end
`endif
         if (!rst && readyPrev && expReady && run_mask[c] && !wrHit[c]) begin
            phase[c]++;
            expCen[c] = ((phase[c] * mNum[c]) / mDen[c]) > (((phase[c] - 1) * mNum[c]) / mDen[c]);
         end else begin
            phase[c]  = 0;
            expCen[c] = 1'b0;
         end
      end
   endtask

   task automatic stepCycle();
      @(posedge refclk);
      modelEdge();
      #1;
      checkOutput("cen", 32'(cen), 32'(expCen));
      checkOutput("rst_out", 32'(rst_out), 32'(!expReady));
      checkOutput("ready", 32'(ready), 32'(expReady));
      checkOutput("unlock_err", 32'(unlock_err), 32'(expErr));
   endtask

   initial begin
      int firstPulse;
      int cnt [4];
      int offCount;
      bit curLocked;
      logic [3:0] curMask;

      for (int c = 0; c < 4; c++) begin
         phase[c] = 0;
         mNum[c]  = longint'(NUM_P[c*16 +: 16]);
         mDen[c]  = longint'(DEN_P[c*16 +: 16]);
      end

      applyStimulus(1'b1, 1'b0, 4'h0);
      stepCycle();
      stepCycle();
      checkOutput("resetCen", 32'(cen), 32'd0);
      checkOutput("resetRstOut", 32'(rst_out), 32'd1);
      checkOutput("resetReady", 32'(ready), 32'd0);
      checkOutput("resetUnlockErr", 32'(unlock_err), 32'd0);

      // Clean lock: rises in cycle 0, release visible in cycle LOCK_HOLD+1.
      applyStimulus(1'b0, 1'b1, 4'hF);
      for (int k = 1; k <= LOCK_HOLD; k++) stepCycle();
      checkOutput("readyBeforeRelease", 32'(ready), 32'd0);
      checkOutput("cenBeforeRelease", 32'(cen), 32'd0);
      stepCycle();
      checkOutput("readyAtRelease", 32'(ready), 32'd1);
      checkOutput("rstOutAtRelease", 32'(rst_out), 32'd0);
      checkOutput("ch0RunCycle1", 32'(cen[0]), 32'd0);

      firstPulse = 0;
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int r = 2; r <= 301; r++) begin
         stepCycle();
         for (int c = 0; c < 4; c++) cnt[c] += int'(cen[c]);
         if (firstPulse == 0 && cen[0]) firstPulse = r;
      end
      checkOutput("ch0Count", 32'(cnt[0]), 32'd100);
      checkOutput("ch1Count", 32'(cnt[1]), 32'd120);
      checkOutput("ch2Count", 32'(cnt[2]), 32'd300);
      checkOutput("ch3Count", 32'(cnt[3]), 32'd0);
      checkOutput("ch0FirstPulse", 32'(firstPulse), 32'd4);

      // Lock glitch during HOLD restarts qualification without flagging an error.
      applyStimulus(1'b1, 1'b0, 4'hF);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 4'hF);
      for (int k = 0; k < 6; k++) stepCycle();
      applyStimulus(1'b0, 1'b0, 4'hF);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 4'hF);
      for (int k = 0; k < LOCK_HOLD; k++) stepCycle();
      checkOutput("glitchReadyEarly", 32'(ready), 32'd0);
      stepCycle();
      checkOutput("glitchReady", 32'(ready), 32'd1);
      checkOutput("glitchUnlockErr", 32'(unlock_err), 32'd0);

      // Lock loss in RUN, then relock: the error flag stays until rst.
      for (int k = 0; k < 5; k++) stepCycle();
      applyStimulus(1'b0, 1'b0, 4'hF);
      stepCycle();
      checkOutput("lossCen", 32'(cen), 32'd0);
      checkOutput("lossRstOut", 32'(rst_out), 32'd1);
      checkOutput("lossReady", 32'(ready), 32'd0);
      checkOutput("lossUnlockErr", 32'(unlock_err), 32'd1);
      applyStimulus(1'b0, 1'b1, 4'hF);
      for (int k = 0; k < 12; k++) stepCycle();
      checkOutput("relockReady", 32'(ready), 32'd1);
      checkOutput("relockUnlockErr", 32'(unlock_err), 32'd1);
      applyStimulus(1'b1, 1'b1, 4'hF);
      stepCycle();
      checkOutput("rstClearsUnlockErr", 32'(unlock_err), 32'd0);
      applyStimulus(1'b0, 1'b1, 4'hF);
      for (int k = 0; k < LOCK_HOLD + 1 + 7; k++) stepCycle();

      // Mask gating on channel 0 discards phase; restart fires on the 4th enabled cycle.
      applyStimulus(1'b0, 1'b1, 4'hE);
      offCount = 0;
      for (int k = 0; k < 10; k++) begin
         stepCycle();
         offCount += int'(cen[0]);
      end
      checkOutput("maskOffPulses", 32'(offCount), 32'd0);
      applyStimulus(1'b0, 1'b1, 4'hF);
      stepCycle();
      checkOutput("maskOnCycle2", 32'(cen[0]), 32'd0);
      stepCycle();
      checkOutput("maskOnCycle3", 32'(cen[0]), 32'd0);
      stepCycle();
      checkOutput("maskOnCycle4", 32'(cen[0]), 32'd1);

`ifdef PLL_CEN_DYN_RATIO_EN
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_num = 16'd1; cfg_den = 16'd4;
      stepCycle();
      cfg_we = 1'b0;
      checkOutput("cfgClearCen", 32'(cen[1]), 32'd0);
      for (int k = 2; k <= 4; k++) stepCycle();
      checkOutput("cfgPeriodEarly", 32'(cen[1]), 32'd0);
      stepCycle();
      checkOutput("cfgPeriodPulse", 32'(cen[1]), 32'd1);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_num = 16'd1; cfg_den = 16'd0;
      stepCycle();
      cfg_we = 1'b0;
      cnt[1] = 0;
      for (int k = 0; k < 40; k++) begin
         stepCycle();
         cnt[1] += int'(cen[1]);
      end
      checkOutput("cfgDenZeroIgnored", 32'(cnt[1]), 32'd10);
`endif

      // Randomized phase: sporadic lock loss, mask changes and resets.
      curLocked = 1'b1;
      curMask   = 4'hF;
      for (int k = 0; k < 3000; k++) begin
         if (curLocked) curLocked = ($urandom_range(0, 299) != 0);
         else curLocked = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) curMask = 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 999) == 0), curLocked, curMask);
`ifdef PLL_CEN_DYN_RATIO_EN
         cfg_we  = ($urandom_range(0, 39) == 0);
         cfg_ch  = 2'($urandom_range(0, 3));
         cfg_num = 16'($urandom_range(0, 9));
         cfg_den = 16'($urandom_range(0, 9));
`endif
         stepCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_cen_gen.md
# pll_cen_gen

Multi-channel clock-enable generator and lock-qualified reset sequencer that sits directly behind the SDRAM/system PLL. It watches the PLL `locked` output and holds a synchronous reset until lock has been stable for a programmable time. It then produces N independent fractional-rate clock-enable pulse trains (CPU, sound, video, etc.) from the single PLL output clock. Unlike the bare PLL wrapper, it handles loss of lock at runtime, gates enables per channel and exposes lock health to the core.

## Interface
Parameters:
- `CHANNELS`, 4, number of clock-enable outputs (1..16)
- `ACC_W`, 16, accumulator/ratio width in bits
- `NUM`, {CHANNELS{16'd1}}, packed per-channel numerators; channel i at `[i*ACC_W +: ACC_W]`
- `DEN`, {CHANNELS{16'd2}}, packed per-channel denominators; nonzero, `NUM<=DEN`
- `LOCK_HOLD`, 1024, cycles `pll_locked` must stay high before release (>=1)

Ports:
- `refclk` in 1: PLL output clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `pll_locked` in 1: PLL lock, already synchronised to `refclk`
- `run_mask` in CHANNELS: per-channel run enable
- `cen` out CHANNELS: single-cycle clock-enable pulses
- `rst_out` out 1: synchronous reset to downstream core
- `ready` out 1: high in RUN state
- `unlock_err` out 1: sticky, lock lost while in RUN

## Operation
- FSM states: WAIT_LOCK, HOLD, RUN.
- WAIT_LOCK: hold counter = 0. `pll_locked`=1 -> HOLD.
- HOLD: counter increments each cycle. `pll_locked`=0 -> WAIT_LOCK with counter cleared. Counter = `LOCK_HOLD-1` with lock still high -> RUN.
- RUN: `pll_locked`=0 -> WAIT_LOCK and set `unlock_err`.
- `rst_out` = 1 in WAIT_LOCK/HOLD and 0 in RUN. `ready` = (state==RUN). Both are registered.
- Per-channel accumulator, computed on `ACC_W+1` bits: `sum = acc + NUM_i`.
  - If `sum >= DEN_i`: `acc <= sum - DEN_i` and `cen_i <= 1`.
  - Else: `acc <= sum` and `cen_i <= 0`.
- Average rate of `cen_i` = `NUM_i/DEN_i`. `NUM=0` never fires. `NUM=DEN` fires every cycle.
- Accumulators update only when state==RUN and `run_mask[i]`=1. Otherwise `acc=0` and `cen_i=0`.
- Leaving RUN clears all accumulators and `cen` in the same edge.
- `unlock_err` clears only on `rst`.
- `rst` has priority over everything: state WAIT_LOCK, counter 0, acc 0.

## Timing
- Reset values: `cen`=0, `rst_out`=1, `ready`=0, `unlock_err`=0, state WAIT_LOCK.
- Lock to release: `pll_locked` rises at cycle 0 -> `ready`=1 and `rst_out`=0 visible at cycle `LOCK_HOLD+1`.
- Lock loss: `pll_locked` falls at cycle t in RUN -> `rst_out`=1, `ready`=0, `unlock_err`=1 and `cen`=0 at t+1.
- First pulse: the first RUN cycle (or first cycle with the mask set) counts as cycle 1. The first `cen_i` pulse is at cycle `ceil(DEN/NUM)+1`, then spacing averages `DEN/NUM`.
- `run_mask` change takes effect on the next edge. Lowering it mid-period discards the accumulated phase.
- Lock loss and `run_mask` change on the same cycle: lock loss dominates.

## Configuration
- `PLL_CEN_DYN_RATIO_EN` defined: adds ports `cfg_we` in 1, `cfg_ch` in `$clog2(CHANNELS)`, `cfg_num` in ACC_W, `cfg_den` in ACC_W.
  - A write stores the ratio into per-channel registers, which reset to `NUM`/`DEN`.
  - The written channel's accumulator clears on the following edge.
  - Writes with `cfg_den`=0 or `cfg_num>cfg_den` are ignored.
- Undefined: ratios are fixed from parameters and the cfg ports are absent.

## Structure
- Package `pll_cen_pkg`: FSM state enum, `ratio_t` struct {num, den}, `HOLD_W` width helper function.
- Sub-module `pll_cen_acc`: one channel's fractional accumulator (inputs: num, den, run, clear; output: cen). Instantiated CHANNELS times via generate.
- Top level holds the FSM, hold counter, sticky flag and optional config registers.

## Test plan
- Reset, then `pll_locked` high at cycle 0 with `LOCK_HOLD=8` -> `rst_out` falls and `ready` rises at cycle 9; `cen`=0 before that.
- Lock glitch: low for 1 cycle at HOLD count 5 -> counter restarts; release 8 cycles after lock re-rises; `unlock_err` stays 0.
- Ratios ch0=1/3, ch1=2/5, ch2=1/1, ch3=0/7 over 300 RUN cycles -> pulse counts 100, 120, 300, 0; ch0 first pulse at RUN cycle 4.
- Drop `pll_locked` in RUN -> next cycle all `cen`=0, `rst_out`=1, `unlock_err`=1. Relock -> `unlock_err` stays 1 until `rst`.
- Toggle `run_mask[0]` off for 10 cycles then on (1/3) -> no pulses while off; first pulse at 4th cycle after re-enable.
- With `PLL_CEN_DYN_RATIO_EN`: write ch1 to 1/4 -> accumulator clears and period becomes 4. Write `den`=0 -> ignored, rate unchanged.
